// File: rtl/accelerator_package.sv
// Shared types and stream layout for the Y block path (scheduler -> fetcher).
`default_nettype none
package accelerator_package;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ0 = 3'd1,
    REQ1 = 3'd2,
    WAIT = 3'd3,
    OUT  = 3'd4
  } y_fetch_state_e;

  localparam int Y_ADDR_LEN_MSB  = 47;
  localparam int Y_ADDR_LEN_LSB  = 32;
  localparam int Y_ADDR_MSB      = 31;
  localparam int Y_ADDR_STREAM_W = 48;

  // Element count of a block: the requested length, capped at the block size.
  function automatic logic [16:0] y_clamp_len(input logic [15:0] len, input logic [16:0] max_n);
    return ({1'b0, len} > max_n) ? max_n : {1'b0, len};
  endfunction

endpackage
`default_nettype wire

// File: rtl/y_block_aligner.sv
// Combinational realignment of one Y block out of two TCDM words, with lane masking.
`default_nettype none
module y_block_aligner #(
  parameter int DATA_SIZE    = 32,
  parameter int Y_BLOCK_SIZE = 4,
  parameter int BUS_WIDTH    = 128
) (
  input  logic [2*BUS_WIDTH-1:0]                  words,
  input  logic [$clog2(BUS_WIDTH/8)-1:0]          off,
  input  logic [$clog2(Y_BLOCK_SIZE):0]           n,
  output logic [DATA_SIZE*Y_BLOCK_SIZE-1:0]       data,
  output logic [DATA_SIZE*Y_BLOCK_SIZE/8-1:0]     strb
);

  localparam int BLK_W      = DATA_SIZE * Y_BLOCK_SIZE;
  localparam int N_W        = $clog2(Y_BLOCK_SIZE) + 1;
  localparam int ELEM_BYTES = DATA_SIZE / 8;

  logic [BLK_W-1:0] window;

  assign window = BLK_W'(words >> {off, 3'b000});

  for (genvar e = 0; e < Y_BLOCK_SIZE; e++) begin : g_lane
    assign data[e*DATA_SIZE +: DATA_SIZE] =
      (N_W'(e) < n) ? window[e*DATA_SIZE +: DATA_SIZE] : '0;
  end

  for (genvar b = 0; b < BLK_W/8; b++) begin : g_strb
    assign strb[b] = (N_W'(b / ELEM_BYTES) < n);
  end

endmodule
`default_nettype wire

// File: rtl/y_block_fetcher.sv
// Fetches one Y block per address beat from TCDM (one or two aligned words) and streams it out.
`default_nettype none
module y_block_fetcher
  import accelerator_package::*;
#(
  parameter int DATA_SIZE    = 32,
  parameter int Y_BLOCK_SIZE = 4,
  parameter int BUS_WIDTH    = 128
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,
  input  logic                                working_i,
  input  logic                                addr_valid_i,
  input  logic [Y_ADDR_STREAM_W-1:0]          addr_data_i,
  output logic                                addr_ready_o,
  output logic                                mem_req_o,
  input  logic                                mem_gnt_i,
  output logic [31:0]                         mem_add_o,
  output logic                                mem_wen_o,
  output logic [BUS_WIDTH/8-1:0]              mem_be_o,
  input  logic                                mem_r_valid_i,
  input  logic [BUS_WIDTH-1:0]                mem_r_data_i,
  output logic                                data_valid_o,
  output logic [DATA_SIZE*Y_BLOCK_SIZE-1:0]   data_data_o,
  output logic [DATA_SIZE*Y_BLOCK_SIZE/8-1:0] data_strb_o,
  input  logic                                data_ready_i,
  output logic                                busy_o
);

  localparam int BE_W  = BUS_WIDTH / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int N_W   = $clog2(Y_BLOCK_SIZE) + 1;

  localparam logic [16:0] MAX_N      = 17'(Y_BLOCK_SIZE);
  localparam logic [16:0] ELEM_BYTES = 17'(DATA_SIZE / 8);
  localparam logic [16:0] WORD_BYTES = 17'(BE_W);

  y_fetch_state_e state, state_next;

  logic [31:0]          base;
  logic [OFF_W-1:0]     off;
  logic [N_W-1:0]       n;
  logic                 span2;
  logic [BUS_WIDTH-1:0] word0;
  logic [BUS_WIDTH-1:0] word1;
  logic                 second_resp;

  logic [15:0] beat_len;
  logic [31:0] beat_addr;
  logic [16:0] beat_n;
  logic [16:0] beat_end;
  logic        beat_span2;
  logic        accept;
  logic        start;

  assign beat_len   = addr_data_i[Y_ADDR_LEN_MSB:Y_ADDR_LEN_LSB];
  assign beat_addr  = addr_data_i[Y_ADDR_MSB:0];
  assign beat_n     = y_clamp_len(beat_len, MAX_N);
  assign beat_end   = 17'(beat_addr[OFF_W-1:0]) + beat_n * ELEM_BYTES;
  assign beat_span2 = beat_end > WORD_BYTES;

  // A zero-length beat is consumed here but never starts a fetch.
  assign accept = addr_valid_i && working_i && (state == IDLE);
  assign start  = accept && (beat_len != 16'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    addr_ready_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_add_o    = 32'd0;
    data_valid_o = 1'b0;
    case (state)
      IDLE: begin
        addr_ready_o = working_i;
        if (start) state_next = REQ0;
      end
      REQ0: begin
        mem_req_o = 1'b1;
        mem_add_o = base;
        if (mem_gnt_i) state_next = span2 ? REQ1 : WAIT;
      end
      REQ1: begin
        mem_req_o = 1'b1;
        mem_add_o = base + 32'(BE_W);
        if (mem_gnt_i) state_next = WAIT;
      end
      WAIT: begin
        state_next = OUT;
      end
      OUT: begin
        data_valid_o = 1'b1;
        if (data_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Responses land in REQ1/WAIT only; the first goes to word0, the second to word1.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      base        <= 32'd0;
      off         <= '0;
      n           <= '0;
      span2       <= 1'b0;
      word0       <= '0;
      word1       <= '0;
      second_resp <= 1'b0;
    end else begin
      if (start) begin
        base        <= {beat_addr[31:OFF_W], {OFF_W{1'b0}}};
        off         <= beat_addr[OFF_W-1:0];
        n           <= N_W'(beat_n);
        span2       <= beat_span2;
        second_resp <= 1'b0;
      end
      if (((state == REQ1) || (state == WAIT)) && mem_r_valid_i) begin
        if (!second_resp) begin
          word0 <= mem_r_data_i;
        end else begin
          word1 <= mem_r_data_i;
        end
        second_resp <= 1'b1;
      end
    end
  end

  logic [BUS_WIDTH-1:0] upper_word;

  assign upper_word = span2 ? word1 : '0;

  y_block_aligner #(
    .DATA_SIZE   (DATA_SIZE),
    .Y_BLOCK_SIZE(Y_BLOCK_SIZE),
    .BUS_WIDTH   (BUS_WIDTH)
  ) u_aligner (
    .words({upper_word, word0}),
    .off  (off),
    .n    (n),
    .data (data_data_o),
    .strb (data_strb_o)
  );

  assign mem_wen_o = 1'b1;
  assign mem_be_o  = '1;
  assign busy_o    = (state != IDLE);

endmodule
`default_nettype wire
